sm_trace_buffer: RTL and testbench
==================================

SM_TRACE_BUFFER -- requirements
Module: sm_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of trace entries; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 32: width of each of the pc, instr and data fields.
REQ-003 SHALL have parameter TIMEOUT, default 120: retirement count that freezes capture; 0 disables the timeout.
REQ-004 SHALL have parameter LOOP_N, default 4: number of consecutive same-pc retirements flagged as a halt.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  DATA_W  pc of the retiring instruction.
- ret_instr  in  DATA_W  instruction word.
- ret_data  in  DATA_W  watched register value (a0).
- mode  in  2  0 = circular, 1 = fill-once, 2 = trigger; 3 is treated as 0.
- trig_pc  in  DATA_W  trigger pc for mode 2.
- clear  in  1  rearm the buffer.
- rd_idx  in  clog2(DEPTH)  logical read index; 0 is the oldest entry.
- rd_entry  out  3*DATA_W  {pc, instr, data} read result.
- count  out  clog2(DEPTH)+1  number of valid entries.
- state  out  2  0 = ARMED, 1 = CAPTURE, 2 = FROZEN.
- timeout  out  1  sticky timeout flag.
- halted  out  1  sticky halt (loop) flag.
- ret_cnt  out  32  retirements since reset or clear.

Function
REQ-006 ARMED: a retirement is captured when mode != 2, or when ret_pc == trig_pc; that capture moves the block to CAPTURE.
REQ-007 CAPTURE: every ret_valid writes {ret_pc, ret_instr, ret_data} at wptr; wptr increments mod DEPTH; count saturates at DEPTH.
REQ-008 Mode 0 or 2 while full: the new write overwrites the oldest entry; count stays at DEPTH.
REQ-009 Mode 1: the write that brings count to DEPTH is stored, and the block enters FROZEN on the same clock edge.
REQ-010 ret_cnt increments on every ret_valid in every state and saturates at all-ones.
REQ-011 When TIMEOUT != 0 and ret_cnt reaches TIMEOUT: timeout is set to 1 (sticky); that retirement is captured if the block is capturing; the block enters FROZEN.
REQ-012 Halt: the LOOP_N-th consecutive retirement with an unchanged pc sets halted to 1 (sticky); that retirement is captured; the block enters FROZEN.
REQ-013 FROZEN: no writes; ret_cnt keeps counting; the block leaves FROZEN only via clear or rst.
REQ-014 clear, from any state: on the next cycle state = ARMED and count, wptr, ret_cnt, timeout and halted are all 0; storage contents are untouched.
REQ-015 clear takes priority over a simultaneous ret_valid; that retirement is neither captured nor counted.
REQ-016 rd_entry is registered with 1-cycle latency and reads physical slot (wptr - count + rd_idx) mod DEPTH.
REQ-017 When rd_idx >= count, rd_entry SHALL be 0.
REQ-018 Reading while writing the same cycle returns the pre-write contents.
REQ-019 mode is sampled every cycle; a change takes effect on the next retirement.

Reset
REQ-020 rst (synchronous, active-high) SHALL force state = ARMED and rd_entry, count, timeout, halted, ret_cnt, wptr and the loop counter to 0.
REQ-021 Storage SHALL NOT be reset.
REQ-022 rst asserted mid-capture behaves as clear and has priority over clear.

Configuration
REQ-023 Macro SM_TRACE_LOOP_DETECT_EN defined: the loop detector of REQ-012 is present.
REQ-024 Macro undefined: halted is tied to 0, no pc-compare or loop-counter logic is generated, and LOOP_N is ignored.

Structure
REQ-025 Package sm_trace_pkg SHALL hold the state encoding, the mode constants and the entry struct {pc, instr, data}.
REQ-026 Sub-module sm_trace_ram SHALL provide DEPTH x 3*DATA_W storage with one write port and one registered read port; control logic stays in sm_trace_buffer.

Verification
REQ-027 Mode 0; pcs 0, 4, ..., 76 (20 retirements) -> count = 16, state = CAPTURE; rd_idx 0 gives pc 16; rd_idx 15 gives pc 76.
REQ-028 Mode 1; same 20 pcs -> FROZEN after the 16th retirement; rd_idx 15 gives pc 60; ret_cnt = 20.
REQ-029 Mode 2, trig_pc = 0x20; pcs 0x00 to 0x3C step 4 -> rd_idx 0 gives pc 0x20; count = 8.
REQ-030 TIMEOUT = 10, mode 0; 14 retirements -> timeout = 1 after the 10th, FROZEN, count = 10, ret_cnt = 14.
REQ-031 Macro on, LOOP_N = 4; pcs 0, 4, 8, 8, 8, 8 -> halted = 1 and FROZEN after the 6th, count = 6; macro off -> halted stays 0, count = 6.
REQ-032 In FROZEN, clear together with ret_valid -> next cycle state = ARMED, count = 0, ret_cnt = 0, flags 0; rst mid-capture gives the same result.

Source files
------------

// File: rtl/sm_trace_pkg.sv
// Shared types for the retirement trace buffer: FSM state encoding, capture modes and entry layout.
package sm_trace_pkg;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } trace_state_e;

  localparam logic [1:0] MODE_CIRC = 2'd0;
  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;

  // Field width of the default build; the buffer itself is parameterised by DATA_W.
  localparam int unsigned ENTRY_FIELD_W = 32;

  typedef struct packed {
    logic [ENTRY_FIELD_W-1:0] pc;
    logic [ENTRY_FIELD_W-1:0] instr;
    logic [ENTRY_FIELD_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/sm_trace_ram.sv
// Trace storage: one write port, one registered read port; storage itself is never reset.
module sm_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register returns pre-write contents on a same-cycle collision; zero when not enabled.
  always_ff @(posedge clk) begin
    if (rst || !rd_en) rd_data <= '0;
    else               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sm_trace_buffer.sv
// Retirement trace buffer with circular / fill-once / trigger capture, timeout and halt freeze.
// Optional loop (halt) detector enabled by defining SM_TRACE_LOOP_DETECT_EN.
module sm_trace_buffer
  import sm_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 120,
  parameter int unsigned LOOP_N  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ret_valid,
  input  logic [DATA_W-1:0]          ret_pc,
  input  logic [DATA_W-1:0]          ret_instr,
  input  logic [DATA_W-1:0]          ret_data,
  input  logic [1:0]                 mode,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [3*DATA_W-1:0]        rd_entry,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       timeout,
  output logic                       halted,
  output logic [31:0]                ret_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LOOP_N == 0) begin : g_param_check
    $error("sm_trace_buffer: DEPTH must be a power of two >= 2 and LOOP_N >= 1");
  end

  trace_state_e    state_q, state_next;
  logic [AW-1:0]   wptr;
  logic [1:0]      mode_eff;
  logic [31:0]     ret_inc;
  logic            full, capture_ok, wr_en, freeze, timeout_hit, loop_hit;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;

  always_comb begin
    mode_eff    = (mode == 2'd3) ? MODE_CIRC : mode;
    ret_inc     = (ret_cnt == '1) ? ret_cnt : ret_cnt + 32'd1;
    full        = (count == CW'(DEPTH));
    timeout_hit = (TIMEOUT != 0) && ret_valid && !clear && (ret_inc == 32'(TIMEOUT));
    rd_en       = (CW'(rd_idx) < count);
    rd_addr     = wptr - AW'(count) + rd_idx;
  end

  // Next-state and capture decision; clear overrides any retirement in the same cycle.
  always_comb begin
    state_next = state_q;
    capture_ok = 1'b0;
    wr_en      = 1'b0;
    freeze     = 1'b0;
    case (state_q)
      ST_ARMED:   capture_ok = (mode_eff != MODE_TRIG) || (ret_pc == trig_pc);
      ST_CAPTURE: capture_ok = 1'b1;
      default:    capture_ok = 1'b0;
    endcase
    if (clear) begin
      state_next = ST_ARMED;
    end else if (ret_valid) begin
      // Fill-once never overwrites: a full buffer in that mode only freezes.
      wr_en  = capture_ok && !(mode_eff == MODE_FILL && full);
      freeze = (state_q != ST_FROZEN) &&
               (timeout_hit || loop_hit ||
                (capture_ok && mode_eff == MODE_FILL && count >= CW'(DEPTH - 1)));
      if (freeze)          state_next = ST_FROZEN;
      else if (capture_ok) state_next = ST_CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ARMED;
    else     state_q <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr    <= '0;
      count   <= '0;
      ret_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (ret_valid)   ret_cnt <= ret_inc;
      if (timeout_hit) timeout <= 1'b1;
      if (wr_en) begin
        wptr <= wptr + AW'(1);
        if (!full) count <= count + CW'(1);
      end
    end
  end

`ifdef SM_TRACE_LOOP_DETECT_EN
  localparam int unsigned LW = $clog2(LOOP_N + 1);

  logic [DATA_W-1:0] last_pc;
  logic [LW-1:0]     loop_cnt, loop_next;

  // Run length of the current pc; zero means no previous retirement to compare against.
  always_comb begin
    if (loop_cnt != '0 && ret_pc == last_pc)
      loop_next = (loop_cnt == LW'(LOOP_N)) ? loop_cnt : loop_cnt + LW'(1);
    else
      loop_next = LW'(1);
    loop_hit = ret_valid && !clear && (loop_next == LW'(LOOP_N));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      loop_cnt <= '0;
      halted   <= 1'b0;
    end else if (ret_valid) begin
      loop_cnt <= loop_next;
      if (loop_hit) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ret_valid) last_pc <= ret_pc;
  end
`else
  assign loop_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign state = state_q;

  sm_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (3 * DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data ({ret_pc, ret_instr, ret_data}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Self-checking bench for sm_trace_buffer: table of capture scenarios plus hand-written corner sequences.
module tb_sm_trace_buffer;
  import sm_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ret_valid, clear;
  logic [31:0] ret_pc, ret_instr, ret_data, trig_pc;
  logic [1:0]  mode;
  logic [3:0]  rd_idx;

  logic [95:0] rd_entry, rd_entry_t;
  logic [4:0]  count, count_t;
  logic [1:0]  state, state_t;
  logic        timeout, timeout_t, halted, halted_t;
  logic [31:0] ret_cnt, ret_cnt_t;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  trace_entry_t exp_q[$];

  always #5 clk = ~clk;

  sm_trace_buffer #(.DEPTH(16), .DATA_W(32), .TIMEOUT(120), .LOOP_N(4)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_data(ret_data), .mode(mode), .trig_pc(trig_pc), .clear(clear), .rd_idx(rd_idx),
    .rd_entry(rd_entry), .count(count), .state(state), .timeout(timeout), .halted(halted),
    .ret_cnt(ret_cnt)
  );

  sm_trace_buffer #(.DEPTH(16), .DATA_W(32), .TIMEOUT(10), .LOOP_N(4)) dut_t (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_data(ret_data), .mode(mode), .trig_pc(trig_pc), .clear(clear), .rd_idx(rd_idx),
    .rd_entry(rd_entry_t), .count(count_t), .state(state_t), .timeout(timeout_t),
    .halted(halted_t), .ret_cnt(ret_cnt_t)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] trig;
    int unsigned n;
    int unsigned idx;
    int unsigned e_count;
    logic [1:0]  e_state;
    int unsigned e_rc;
    bit          e_zero;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[10];

  function automatic trace_entry_t exp_entry(input logic [31:0] pc);
    trace_entry_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'hC0DE_0000;
    e.data  = ~pc;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic retire(input logic [31:0] pc);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_instr = pc ^ 32'hC0DE_0000;
    ret_data  = ~pc;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Scoreboarded read: expectation queued when rd_idx is driven, compared when rd_entry appears.
  task automatic read_check(input string name, input int unsigned idx, input bit zero,
                            input logic [31:0] pc);
    trace_entry_t e;
    rd_idx = 4'(idx);
    e = zero ? trace_entry_t'('0) : exp_entry(pc);
    exp_q.push_back(e);
    tick();
    chk(name, rd_entry, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; ret_valid = 1'b0; clear = 1'b0; mode = 2'd0; trig_pc = '0;
    ret_pc = '0; ret_instr = '0; ret_data = '0; rd_idx = '0;

    vecs[0] = '{2'd0, 32'h0,  20, 0,  16, ST_CAPTURE, 20, 1'b0, 32'd16};
    vecs[1] = '{2'd0, 32'h0,  20, 15, 16, ST_CAPTURE, 20, 1'b0, 32'd76};
    vecs[2] = '{2'd1, 32'h0,  20, 15, 16, ST_FROZEN,  20, 1'b0, 32'd60};
    vecs[3] = '{2'd1, 32'h0,  20, 0,  16, ST_FROZEN,  20, 1'b0, 32'd0};
    vecs[4] = '{2'd2, 32'h20, 16, 0,  8,  ST_CAPTURE, 16, 1'b0, 32'h20};
    vecs[5] = '{2'd2, 32'h20, 16, 7,  8,  ST_CAPTURE, 16, 1'b0, 32'h3C};
    vecs[6] = '{2'd2, 32'h20, 16, 8,  8,  ST_CAPTURE, 16, 1'b1, 32'h0};
    vecs[7] = '{2'd3, 32'h0,  5,  4,  5,  ST_CAPTURE, 5,  1'b0, 32'd16};
    vecs[8] = '{2'd3, 32'h0,  5,  5,  5,  ST_CAPTURE, 5,  1'b1, 32'h0};
    vecs[9] = '{2'd0, 32'h0,  0,  0,  0,  ST_ARMED,   0,  1'b1, 32'h0};

    tick(); tick();
    rst = 1'b0;
    chk("rst_state",   96'(state),    96'(ST_ARMED));
    chk("rst_count",   96'(count),    96'(0));
    chk("rst_ret_cnt", 96'(ret_cnt),  96'(0));
    chk("rst_timeout", 96'(timeout),  96'(0));
    chk("rst_halted",  96'(halted),   96'(0));
    chk("rst_rd",      rd_entry,      96'(0));

    foreach (vecs[i]) begin
      do_clear();
      mode = vecs[i].mode;
      trig_pc = vecs[i].trig;
      for (int k = 0; k < int'(vecs[i].n); k++) retire(32'(k * 4));
      chk($sformatf("row%0d_count", i),   96'(count),   96'(vecs[i].e_count));
      chk($sformatf("row%0d_state", i),   96'(state),   96'(vecs[i].e_state));
      chk($sformatf("row%0d_ret_cnt", i), 96'(ret_cnt), 96'(vecs[i].e_rc));
      read_check($sformatf("row%0d_rd", i), vecs[i].idx, vecs[i].e_zero, vecs[i].e_pc);
    end

    // Timeout at 10 on the short-timeout instance; default instance is unaffected.
    do_clear();
    mode = 2'd0;
    for (int k = 0; k < 9; k++) retire(32'(k * 4));
    chk("to_before_flag",  96'(timeout_t), 96'(0));
    chk("to_before_state", 96'(state_t),   96'(ST_CAPTURE));
    retire(32'd36);
    chk("to_flag",  96'(timeout_t), 96'(1));
    chk("to_state", 96'(state_t),   96'(ST_FROZEN));
    chk("to_count", 96'(count_t),   96'(10));
    for (int k = 10; k < 14; k++) retire(32'(k * 4));
    chk("to_count_after",  96'(count_t),   96'(10));
    chk("to_ret_cnt",      96'(ret_cnt_t), 96'(14));
    chk("to_default_flag", 96'(timeout),   96'(0));
    rd_idx = 4'd9;
    tick();
    chk("to_last_entry", rd_entry_t, 96'(exp_entry(32'd36)));

    // Loop detection on a repeated pc.
    do_clear();
    mode = 2'd0;
    retire(32'd0); retire(32'd4); retire(32'd8); retire(32'd8); retire(32'd8);
    chk("loop_pre_halt", 96'(halted), 96'(0));
    retire(32'd8);
    chk("loop_count", 96'(count), 96'(6));
`ifdef SM_TRACE_LOOP_DETECT_EN
    chk("loop_halted", 96'(halted), 96'(1));
    chk("loop_state",  96'(state),  96'(ST_FROZEN));
    retire(32'd12);
    chk("loop_frozen_count", 96'(count), 96'(6));
`else
    chk("loop_halted", 96'(halted), 96'(0));
    chk("loop_state",  96'(state),  96'(ST_CAPTURE));
    retire(32'd12);
    chk("loop_frozen_count", 96'(count), 96'(7));
`endif

    // Clear together with a retirement while frozen.
    do_clear();
    mode = 2'd1;
    for (int k = 0; k < 16; k++) retire(32'(k * 4));
    chk("clr_pre_state", 96'(state),     96'(ST_FROZEN));
    chk("clr_pre_to",    96'(timeout_t), 96'(1));
    clear = 1'b1;
    retire(32'd200);
    clear = 1'b0;
    chk("clr_state",   96'(state),     96'(ST_ARMED));
    chk("clr_count",   96'(count),     96'(0));
    chk("clr_ret_cnt", 96'(ret_cnt),   96'(0));
    chk("clr_timeout", 96'(timeout_t), 96'(0));
    chk("clr_halted",  96'(halted),    96'(0));

    // Reset mid-capture, asserted alongside clear and a retirement.
    mode = 2'd0;
    for (int k = 0; k < 5; k++) retire(32'(k * 4));
    chk("rstm_pre_state", 96'(state), 96'(ST_CAPTURE));
    rd_idx = 4'd0;
    rst = 1'b1; clear = 1'b1;
    retire(32'd300);
    rst = 1'b0; clear = 1'b0;
    chk("rstm_state",   96'(state),   96'(ST_ARMED));
    chk("rstm_count",   96'(count),   96'(0));
    chk("rstm_ret_cnt", 96'(ret_cnt), 96'(0));
    chk("rstm_rd",      rd_entry,     96'(0));

    // Read of the slot being overwritten returns the old entry.
    mode = 2'd0;
    for (int k = 0; k < 16; k++) retire(32'(k * 4));
    rd_idx = 4'd0;
    exp_q.push_back(exp_entry(32'd0));
    retire(32'd1000);
    chk("rdw_old", rd_entry, exp_q.pop_front());
    read_check("rdw_newest", 15, 1'b0, 32'd1000);
    read_check("rdw_oldest", 0,  1'b0, 32'd4);
    chk("rdw_count", 96'(count), 96'(16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
